// File: rtl/bubble_sort_pkg.sv
// Shared types and default widths for the in-place bubble sort sequencer, its memory and the sort top.
// Early-exit option is selected by BUBBLE_SORT_EARLY_EXIT_EN in the controller.
package bubble_sort_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 1024;
  localparam int DEFAULT_CNT_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CMP,
    WR_LO,
    WR_HI,
    DONE
  } sort_state_e;

endpackage

// File: rtl/bubble_sort_ctrl.sv
// In-place ascending unsigned bubble sort over a single-port memory; BUBBLE_SORT_EARLY_EXIT_EN stops after a swap-free pass.
// Busy for 3 cycles per compare plus 2 per swap, done pulses next cycle; start is ignored while busy.
module bubble_sort_ctrl
  import bubble_sort_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  swap_count,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  sort_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [CNT_WIDTH-1:0]  swap_count_q, swap_count_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  logic                  swapped_q, swapped_d;
`endif

  logic [LW-1:0] n_eff;
  logic          pass_more;
  logic          pass_clean;
  logic          advance;

  always_comb begin
    n_eff     = (len > DEPTH_L) ? DEPTH_L : len;
    pass_more = (LW'(i_q) + LW'(1)) < LW'(last_q);
  end

  // A pass that moved nothing means the remaining prefix is already ordered.
  always_comb begin
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    pass_clean = !(swapped_q || (state_q == WR_HI));
`else
    pass_clean = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    last_d       = last_q;
    a_d          = a_q;
    b_d          = b_q;
    swap_count_d = swap_count_q;
    advance      = 1'b0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    swapped_d    = swapped_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          swap_count_d = '0;
          i_d          = '0;
          last_d       = ADDR_WIDTH'(n_eff - LW'(1));
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
          swapped_d    = 1'b0;
`endif
          state_d      = (n_eff <= LW'(1)) ? DONE : RD_A;
        end
      end
      RD_A: begin
        a_d     = mem_rdata;
        state_d = RD_B;
      end
      RD_B: begin
        b_d     = mem_rdata;
        state_d = CMP;
      end
      CMP: begin
        // Strict compare keeps equal keys in place, so the sort is stable.
        if (a_q > b_q) begin
          state_d = WR_LO;
        end else begin
          advance = 1'b1;
        end
      end
      WR_LO: begin
        state_d = WR_HI;
      end
      WR_HI: begin
        if (swap_count_q != {CNT_WIDTH{1'b1}}) begin
          swap_count_d = swap_count_q + CNT_WIDTH'(1);
        end
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
        swapped_d = 1'b1;
`endif
        advance = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (pass_more) begin
        i_d     = i_q + ADDR_WIDTH'(1);
        state_d = RD_A;
      end else begin
        i_d    = '0;
        last_d = last_q - ADDR_WIDTH'(1);
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
        swapped_d = 1'b0;
`endif
        state_d = ((last_q == ADDR_WIDTH'(1)) || pass_clean) ? DONE : RD_A;
      end
    end
  end

  // Port outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    busy_d      = !((state_d == IDLE) || (state_d == DONE));
    done_d      = (state_d == DONE);
    mem_read_d  = (state_d == RD_A) || (state_d == RD_B);
    mem_write_d = (state_d == WR_LO) || (state_d == WR_HI);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_d)
      RD_A:    mem_addr_d = i_d;
      RD_B:    mem_addr_d = i_d + ADDR_WIDTH'(1);
      WR_LO: begin
        mem_addr_d  = i_d;
        mem_wdata_d = b_d;
      end
      WR_HI: begin
        mem_addr_d  = i_d + ADDR_WIDTH'(1);
        mem_wdata_d = a_d;
      end
      default: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      i_q          <= '0;
      last_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      swap_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
      swapped_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      last_q       <= last_d;
      a_q          <= a_d;
      b_q          <= b_d;
      swap_count_q <= swap_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
      swapped_q    <= swapped_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign swap_count = swap_count_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl: behavioural memory, reference bubble sort scoreboard, bus-rule monitor.
module tb_bubble_sort_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [CW-1:0] swap_count;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [DEPTH];

  int vectors     = 0;
  int miscompares = 0;
  int busy_cnt    = 0;
  int rd_cnt      = 0;
  int wr_cnt      = 0;
  int viol        = 0;
  int cur_n       = 0;
  logic [DW-1:0] rd_prev = '0;
  logic [DW-1:0] rd_last = '0;

  typedef struct {
    int swaps;
    int cmps;
    int n;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] dat_q[$];

  bubble_sort_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .swap_count(swap_count),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr] : '0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] = mem_wdata;
  end

  // Bus rules: exclusive read/write, access only while busy and inside the active range,
  // idle address parked at zero, and no write right after reading an equal pair.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (mem_read) begin
      rd_cnt++;
      rd_prev = rd_last;
      rd_last = mem_rdata;
    end
    if (mem_write) begin
      wr_cnt++;
      if (rd_prev == rd_last) viol++;
    end
    if (mem_read && mem_write) viol++;
    if ((mem_read || mem_write) && (!busy || int'(mem_addr) >= cur_n)) viol++;
    if (!(mem_read || mem_write) && mem_addr != '0) viol++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int n);
    logic [DW-1:0] a [DEPTH];
    logic [DW-1:0] t;
    int sw;
    int cm;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    bit moved;
`endif
    sw = 0;
    cm = 0;
    for (int k = 0; k < DEPTH; k++) a[k] = mem[k];
    for (int last = n - 1; last >= 1; last--) begin
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
      moved = 1'b0;
`endif
      for (int k = 0; k < last; k++) begin
        cm++;
        if (a[k] > a[k+1]) begin
          t = a[k];
          a[k] = a[k+1];
          a[k+1] = t;
          sw++;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
          moved = 1'b1;
`endif
        end
      end
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
      if (!moved) break;
`endif
    end
    exp_q.push_back('{sw, cm, n});
    for (int k = 0; k < n; k++) dat_q.push_back(a[k]);
  endtask

  task automatic run_sort(input int len_v, input bit poke, input string tag);
    int n;
    int waited;
    exp_t e;
    logic [DW-1:0] w;
    logic [CW-1:0] held;
    n = (len_v > DEPTH) ? DEPTH : len_v;
    push_expected(n);
    @(negedge clk);
    len      = (AW+1)'(len_v);
    start    = 1'b1;
    busy_cnt = 0;
    rd_cnt   = 0;
    wr_cnt   = 0;
    viol     = 0;
    cur_n    = n;
    @(negedge clk);
    start  = 1'b0;
    len    = (AW+1)'($urandom);
    waited = 1;
    while (!done && waited < 5000) begin
      if (poke) start = (waited == 4 || waited == 9);
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    chk({tag, ":done_seen"}, done, 1);
    e = exp_q.pop_front();
    chk({tag, ":swap_count"}, swap_count, e.swaps);
    chk({tag, ":busy_cycles"}, busy_cnt, 3 * e.cmps + 2 * e.swaps);
    chk({tag, ":done_latency"}, waited, 3 * e.cmps + 2 * e.swaps + 1);
    chk({tag, ":reads"}, rd_cnt, 2 * e.cmps);
    chk({tag, ":writes"}, wr_cnt, 2 * e.swaps);
    chk({tag, ":bus_rules"}, viol, 0);
    for (int k = 0; k < e.n; k++) begin
      w = dat_q.pop_front();
      chk($sformatf("%s:mem[%0d]", tag, k), mem[k], w);
    end
    held = swap_count;
    @(negedge clk);
    chk({tag, ":done_single"}, done, 0);
    chk({tag, ":busy_after"}, busy, 0);
    chk({tag, ":swap_hold"}, swap_count, held);
  endtask

  task automatic load4(input int a, input int b, input int c, input int d);
    mem[0] = DW'(a);
    mem[1] = DW'(b);
    mem[2] = DW'(c);
    mem[3] = DW'(d);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":done"}, done, 0);
    chk({tag, ":mem_read"}, mem_read, 0);
    chk({tag, ":mem_write"}, mem_write, 0);
    chk({tag, ":mem_addr"}, mem_addr, 0);
    chk({tag, ":mem_wdata"}, mem_wdata, 0);
    chk({tag, ":swap_count"}, swap_count, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    len   = '0;
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    load4(4, 3, 2, 1);
    run_sort(4, 1'b0, "reverse");
    load4(1, 2, 3, 4);
    run_sort(4, 1'b0, "sorted");
    load4(5, 5, 2, 5);
    run_sort(4, 1'b0, "dups");
    run_sort(0, 1'b0, "len0");
    run_sort(1, 1'b0, "len1");

    for (int k = 0; k < 8; k++) mem[k] = DW'(8 - k);
    @(negedge clk);
    len   = (AW+1)'(8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("abort");
    rst = 1'b0;
    run_sort(8, 1'b0, "post_rst");

    for (int k = 0; k < DEPTH; k++) mem[k] = DW'($urandom);
    run_sort(DEPTH + 1, 1'b1, "clamp");

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) mem[k] = DW'($urandom_range(0, 7));
      run_sort($urandom_range(2, DEPTH), 1'b1, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bubble_sort_ctrl.md
Name: bubble_sort_ctrl

Overview:
- Sequencer that sorts the first `len` words of an external single-port memory in place, ascending, unsigned, using bubble sort.
- Owns the memory's read/write/address/data port for the whole operation. Sits beside the memory in the sort top level.
- Memory contract: synchronous write on posedge; combinational read gated by `mem_read`.
- Software-style start/busy/done handshake; reports the swap count.

Parameters:
- ADDR_WIDTH, 10: memory address width.
- DATA_WIDTH, 16: element width, unsigned.
- DEPTH, 1024: memory depth; upper bound on `len`.
- CNT_WIDTH, 32: width of `swap_count`.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sort; sampled only in IDLE.
- len  in  ADDR_WIDTH+1  element count; sampled with an accepted `start`.
- busy  out  1  high while sorting.
- done  out  1  one-cycle pulse at completion.
- swap_count  out  CNT_WIDTH  swaps in the last sort; holds until the next accepted start.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  combinational memory read data.

Behaviour:
- Reset values: `busy`, `done`, `mem_read`, `mem_write` = 0; `mem_addr`, `mem_wdata`, `swap_count` = 0; state = IDLE.
- Reset mid-sort aborts immediately. Memory is left partially sorted; no guarantee on its contents.
- Effective length: n = min(len, DEPTH).
- Start accepted when `start`=1 in IDLE:
  - Clear `swap_count`; set i=0, last=n-1.
  - If n<=1, go straight to DONE.
  - Otherwise go to RD_A.
- `start` while not IDLE is ignored; `len` changes after acceptance are ignored.
- States: IDLE, RD_A, RD_B, CMP, WR_LO, WR_HI, DONE. `busy`=1 in every state except IDLE and DONE.
- RD_A: `mem_read`=1, `mem_addr`=i; capture A=`mem_rdata` at the edge. Go to RD_B.
- RD_B: `mem_read`=1, `mem_addr`=i+1; capture B. Go to CMP.
- CMP: no memory access.
  - If A>B (strict): go to WR_LO.
  - Else (equal elements never swap, so the sort is stable): advance.
- WR_LO: `mem_write`=1, `mem_addr`=i, `mem_wdata`=B. Go to WR_HI.
- WR_HI: `mem_write`=1, `mem_addr`=i+1, `mem_wdata`=A. Increment `swap_count` (saturating at all-ones), then advance.
- Advance:
  - If i+1 < last: i++, go to RD_A.
  - Else end of pass: last--, i=0. If the new last==0, go to DONE; else go to RD_A.
- DONE: `done`=1 for exactly one cycle, `busy`=0. Go to IDLE.
- `mem_read` and `mem_write` are never high together. Outside RD/WR states: `mem_read`=`mem_write`=0, `mem_addr`=0.
- Timing: busy cycles = 3*compares + 2*swaps. Compares = n(n-1)/2 without early exit. `done` rises the cycle after the last CMP/WR_HI.

Optional Feature:
- Macro: BUBBLE_SORT_EARLY_EXIT_EN.
- Defined: a per-pass swap flag is cleared at each pass start. A pass ending with the flag clear goes to DONE regardless of `last`.
- Undefined: all n-1 passes always run; the flag logic is absent.

Decomposition:
- Package `bubble_sort_pkg` holds:
  - state enum `sort_state_e`;
  - default width constants (ADDR_WIDTH, DATA_WIDTH, DEPTH, CNT_WIDTH);
  - shared by the controller, the memory instance and the top level.
- No sub-module; the comparator and index counters are inline. The controller does not instantiate the memory; the top level connects both.

Test Plan:
- Reverse data [4,3,2,1], len=4, early exit off -> memory [1,2,3,4]; swap_count=6; busy for 30 cycles; done pulses once.
- Sorted data [1,2,3,4], len=4 -> no `mem_write` ever; swap_count=0; busy 18 cycles off, 9 cycles with BUBBLE_SORT_EARLY_EXIT_EN.
- Duplicates [5,5,2,5], len=4 -> [2,5,5,5]; swap_count=2; never writes when comparing equal values.
- len=0 and len=1 -> done one cycle after start; busy never high; no memory access; swap_count=0.
- rst asserted mid-sort of 8 elements, then start with len=8 -> all outputs 0 the cycle after reset; second sort completes fully ascending.
- start pulsed while busy, and len=DEPTH+1 -> extra start ignored; len clamped; sort of 1024 random words ends ascending; mem_addr never exceeds 1023.
